cache_bist: RTL
===============

CACHE_BIST -- requirements
Module: cache_bist

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0040, byte address of the first tested word; SHALL be 4-byte aligned.
REQ-002 Parameter WORD_COUNT, default 64, number of 32-bit words tested; range 1..65535.
REQ-003 Parameter SEED, default 32'hA5C3_5A3C, pattern seed.
REQ-004 Parameter TIMEOUT, default 1024, maximum cycles allowed in any wait state.
REQ-005 clk  in  1  single clock; the block and the cache under test run on it.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 start  in  1  a one-cycle pulse in IDLE or DONE begins a run.
REQ-008 address  out  32  byte address to the cache.
REQ-009 data_in  out  32  write data to the cache.
REQ-010 write_enable  out  4  byte-lane write strobes; 0 selects read.
REQ-011 data_out  in  32  cache read data.
REQ-012 data_out_ready  in  1  cache read data is valid.
REQ-013 busy  in  1  cache is evicting or filling.
REQ-014 done  out  1  run finished; held until the next start.
REQ-015 pass  out  1  valid while done=1.
REQ-016 timeout  out  1  failure was a wait timeout.
REQ-017 fail_addr / fail_expected / fail_actual  out  32 each  first-failure capture.

Function
REQ-018 Pattern: pat(i) = SEED ^ {i[15:0], ~i[15:0]}; word i is at BASE_ADDR + 4*i.
REQ-019 States SHALL be IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, BW_ISSUE, BW_WAIT, BR_ISSUE, BR_WAIT, DONE.
REQ-020 Phase 1 (WR_*) SHALL write pat(i) with write_enable=4'b1111 for i=0..WORD_COUNT-1.
REQ-021 Phase 2 (RD_*) SHALL read each word and compare the result with pat(i).
REQ-022 Phase 3 (BW_*) SHALL write data_in={4{~pat(i)[7:0]}} with write_enable=4'b0001<<i[1:0].
REQ-023 Phase 4 (BR_*) SHALL read each word and compare the result with pat(i), with byte lane i[1:0] replaced by ~pat(i)[7:0].
REQ-024 An *_ISSUE state SHALL stay in place while busy=1; with busy=0 it SHALL drive the command and move to *_WAIT on the next edge.
REQ-025 address, data_in and write_enable SHALL be held stable from ISSUE until the wait completes.
REQ-026 A write wait SHALL complete on the first WAIT cycle with busy=0; a cache hit therefore takes one WAIT cycle.
REQ-027 Read data SHALL be sampled only in RD_WAIT/BR_WAIT, on the first cycle with data_out_ready=1; data_out_ready during the ISSUE cycle SHALL be ignored.
REQ-028 write_enable SHALL be driven 0 in every state except WR_*/BW_*.
REQ-029 When the index reaches WORD_COUNT-1 and that access completes, the index SHALL wrap to 0 and the next phase SHALL begin; after phase 4 the block SHALL enter DONE with pass=1.
REQ-030 On the first mismatch, fail_* SHALL be captured and the block SHALL enter DONE with pass=0; there is no further traffic.
REQ-031 The watchdog SHALL clear on entry to every state; if it reaches TIMEOUT in any WAIT or ISSUE state, the block SHALL capture fail_addr, set timeout=1, and enter DONE with pass=0.
REQ-032 A start pulse outside IDLE/DONE SHALL be ignored.
REQ-033 A start pulse in DONE SHALL clear done, pass, timeout and fail_* in the same edge and begin phase 1.
REQ-034 A WORD_COUNT=1 run SHALL perform exactly 4 accesses.

Reset
REQ-035 rst_n=0 SHALL asynchronously force IDLE with address=0, data_in=0, write_enable=0, done=0, pass=0, timeout=0, fail_*=0, index=0 and watchdog=0.
REQ-036 A reset mid-run SHALL abandon the run; write_enable SHALL be 0 within reset, so no partial write continues from this block.

Structure
REQ-037 State encodings, the pattern function and the byte-merge function SHALL reside in a shared include or package, cache_bist_pkg.
REQ-038 The watchdog SHALL be the one sub-module, bist_watchdog, with clear/enable inputs and an expired output.
REQ-039 All outputs SHALL be registered.

Verification
REQ-040 Against Cache (LINE_IX_BITWIDTH=1) plus BurstRAM, with WORD_COUNT=32 and BASE_ADDR=64 -> done=1, pass=1; evictions occur.
REQ-041 Stub cache with a 3-cycle miss busy, where word 5 reads back as pat(5)^1 in phase 2 -> pass=0, fail_addr=32'h54, fail_actual=fail_expected^1.
REQ-042 Stub cache holding busy=1 forever after the first write -> done=1, timeout=1, fail_addr=32'h40, after TIMEOUT cycles.
REQ-043 Stub cache asserting data_out_ready during the ISSUE cycle with stale data -> the stale value is ignored and pass=1.
REQ-044 rst_n pulsed low during phase 3, then start -> all outputs reach their reset values immediately, and the next run passes.
REQ-045 WORD_COUNT=1, BASE_ADDR=0 -> exactly 4 accesses; the phase-3 strobe is 4'b0001; pass=1.

Source files
------------

// File: rtl/cache_bist_pkg.sv
// -----------------------------------------------------------------------------
// cache_bist_pkg
// Shared definitions for the cache BIST engine: FSM state encodings, the
// per-word test pattern and the byte-lane merge used by the byte-write phase.
// Each *_WAIT encoding is its *_ISSUE encoding plus one, and each phase's
// *_WAIT plus one is the next phase's *_ISSUE (BR_WAIT + 1 is DONE). The FSM
// relies on this ordering to step between states.
// -----------------------------------------------------------------------------
package cache_bist_pkg;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_WR_ISSUE = 4'd1;
   localparam logic [3:0] ST_WR_WAIT  = 4'd2;
   localparam logic [3:0] ST_RD_ISSUE = 4'd3;
   localparam logic [3:0] ST_RD_WAIT  = 4'd4;
   localparam logic [3:0] ST_BW_ISSUE = 4'd5;
   localparam logic [3:0] ST_BW_WAIT  = 4'd6;
   localparam logic [3:0] ST_BR_ISSUE = 4'd7;
   localparam logic [3:0] ST_BR_WAIT  = 4'd8;
   localparam logic [3:0] ST_DONE     = 4'd9;

   // Full-word test pattern for word index idx.
   function automatic logic [31:0] pat(input logic [31:0] seed, input logic [15:0] idx);
      return seed ^ {idx, ~idx};
   endfunction

   // Replace byte lane 'lane' of 'word' with 'byte_v'.
   function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  byte_v);
      logic [31:0] r;
      r = word;
      r[{lane, 3'b000} +: 8] = byte_v;
      return r;
   endfunction

endpackage

// File: rtl/cache_bist_watchdog.sv
// -----------------------------------------------------------------------------
// bist_watchdog
// Cycle counter bounding how long the BIST may sit in one state.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (asserted on the edge a state is entered)
//   enable     : count this cycle
//   expired    : high during the TIMEOUT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module bist_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   // count is 0 in the first cycle of a state, so LAST marks cycle TIMEOUT.
   assign expired = enable && (count == LAST);

endmodule

// File: rtl/cache_bist.sv
// -----------------------------------------------------------------------------
// cache_bist
// Four-phase built-in self test for a word-addressed cache:
//   1 write pat(i) to every word, 2 read back and compare,
//   3 write one byte lane (lane i[1:0]) with ~pat(i)[7:0], 4 read back merged.
// Stops on the first mismatch or on a watchdog timeout in any ISSUE/WAIT state.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle pulse, honoured only in IDLE or DONE
//   address, data_in  : byte address and write data to the cache
//   write_enable      : byte strobes, 0 means read
//   data_out          : cache read data
//   data_out_ready    : cache read data valid
//   busy              : cache is evicting or filling
//   done, pass        : run finished / run result (valid with done)
//   timeout           : failure was a watchdog expiry
//   fail_addr/expected/actual : first-failure capture
// -----------------------------------------------------------------------------
module cache_bist
   import cache_bist_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0040,
   parameter int          WORD_COUNT = 64,
   parameter logic [31:0] SEED       = 32'hA5C3_5A3C,
   parameter int          TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] address,
   output logic [31:0] data_in,
   output logic [3:0]  write_enable,
   input  logic [31:0] data_out,
   input  logic        data_out_ready,
   input  logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] fail_addr,
   output logic [31:0] fail_expected,
   output logic [31:0] fail_actual
);

   localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);

   logic [3:0]  state, state_nxt;
   logic [15:0] idx, idx_nxt;
   logic        acc_done, fail_now, wd_hit;
   logic        wd_clear, wd_enable, wd_expired;
   logic        load_cmd;
   logic [31:0] pat_cur, pat_nxt, rd_expected;
   logic [31:0] cmd_addr, cmd_data;
   logic [3:0]  cmd_we;

   bist_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   assign pat_cur     = pat(SEED, idx);
   assign rd_expected = (state == ST_BR_WAIT) ? byte_merge(pat_cur, idx[1:0], ~pat_cur[7:0])
                                              : pat_cur;

   // Next-state logic
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      acc_done  = 1'b0;
      fail_now  = 1'b0;
      wd_hit    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = ST_WR_ISSUE;
               idx_nxt   = '0;
            end
         end
         ST_WR_ISSUE, ST_RD_ISSUE, ST_BW_ISSUE, ST_BR_ISSUE: begin
            if (!busy) begin
               state_nxt = state + 4'd1;
            end else if (wd_expired) begin
               wd_hit = 1'b1;
            end
         end
         ST_WR_WAIT, ST_BW_WAIT: begin
            if (!busy) begin
               acc_done = 1'b1;
            end else if (wd_expired) begin
               wd_hit = 1'b1;
            end
         end
         ST_RD_WAIT, ST_BR_WAIT: begin
            if (data_out_ready) begin
               if (data_out != rd_expected) begin
                  fail_now = 1'b1;
               end else begin
                  acc_done = 1'b1;
               end
            end else if (wd_expired) begin
               wd_hit = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (fail_now || wd_hit) begin
         state_nxt = ST_DONE;
      end else if (acc_done) begin
         if (idx == LAST_IDX) begin
            // Last word of the phase: wrap and step into the next phase
            // (BR_WAIT + 1 is DONE).
            idx_nxt   = '0;
            state_nxt = state + 4'd1;
         end else begin
            idx_nxt   = idx + 16'd1;
            state_nxt = state - 4'd1;
         end
      end
   end

   assign wd_enable = (state != ST_IDLE) && (state != ST_DONE);
   assign wd_clear  = (state_nxt != state);

   // Command presented for the access that starts on the next edge.
   assign pat_nxt  = pat(SEED, idx_nxt);
   assign cmd_addr = BASE_ADDR + {14'b0, idx_nxt, 2'b00};
   assign load_cmd = (state_nxt != state) &&
                     ((state_nxt == ST_WR_ISSUE) || (state_nxt == ST_RD_ISSUE) ||
                      (state_nxt == ST_BW_ISSUE) || (state_nxt == ST_BR_ISSUE));

   always_comb begin
      cmd_we   = 4'b0000;
      cmd_data = 32'h0;
      case (state_nxt)
         ST_WR_ISSUE: begin
            cmd_we   = 4'b1111;
            cmd_data = pat_nxt;
         end
         ST_BW_ISSUE: begin
            cmd_we   = 4'b0001 << idx_nxt[1:0];
            cmd_data = {4{~pat_nxt[7:0]}};
         end
         default: ;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         idx           <= '0;
         address       <= '0;
         data_in       <= '0;
         write_enable  <= '0;
         done          <= 1'b0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
         fail_addr     <= '0;
         fail_expected <= '0;
         fail_actual   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;

         // The command is loaded once on ISSUE entry and held through WAIT.
         if (load_cmd) begin
            address      <= cmd_addr;
            data_in      <= cmd_data;
            write_enable <= cmd_we;
         end

         if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
            done         <= 1'b1;
            pass         <= !(fail_now || wd_hit);
            timeout      <= wd_hit;
            write_enable <= 4'b0000;
            if (fail_now || wd_hit) begin
               fail_addr <= address;
            end
            if (fail_now) begin
               fail_expected <= rd_expected;
               fail_actual   <= data_out;
            end
         end

         if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
         end
      end
   end

endmodule
